// File: rtl/risc_toy_pkg.sv
// rtl/risc_toy_pkg.sv - shared types and constants for the RISC_TOY fetch stage
//
// Contents:
//   fetch_state_e     fetch FSM state encoding (BOOT/RUN/HOLD)
//   IAW, XLEN         instruction word-address width and data width
//   RESET_PC_DEFAULT  default word address of the first fetch after reset
//   word_to_byte()    converts a word address to a byte address

package risc_toy_pkg;

    localparam int IAW  = 30;
    localparam int XLEN = 32;

    localparam logic [IAW-1:0] RESET_PC_DEFAULT = 30'h0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_to_byte(input logic [IAW-1:0] waddr);
        return {waddr, 2'b00};
    endfunction

endpackage

// File: rtl/risc_toy_fetch_skid.sv
// rtl/risc_toy_fetch_skid.sv - one-entry hold buffer for a fetched instruction and its PC
//
// Ports:
//   clk, rst    core clock, asynchronous active-high reset
//   load_i      capture instr_i/pc_i and mark the entry valid
//   clear_i     drop the entry (wins over load_i)
//   instr_i     instruction to capture
//   pc_i        word address of instr_i
//   valid_o     entry holds an instruction
//   instr_o     held instruction
//   pc_o        word address of the held instruction

module risc_toy_fetch_skid
    import risc_toy_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [IAW-1:0]  pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [IAW-1:0]  pc_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [IAW-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/risc_toy_fetch.sv
// rtl/risc_toy_fetch.sv - RISC_TOY instruction-fetch stage (PC, I-mem request, registered ID outputs)
//
// Optional feature macro: RISC_TOY_FETCH_PERF_EN (adds PERF_FETCH / PERF_KILL counters)
//
// Parameters:
//   RESET_PC    word address of the first fetch after reset
// Ports:
//   CLK, RST    core clock, asynchronous active-high reset
//   IREQ        instruction-memory read request
//   IADDR       word address of the request
//   INSTR       read data, valid the cycle after IREQ=1
//   STALL       decode cannot accept; ID outputs hold
//   REDIR       single-cycle redirect pulse from execute
//   REDIR_ADDR  redirect target word address
//   ID_VALID    ID_INSTR/ID_PC hold a live instruction
//   ID_INSTR    fetched instruction
//   ID_PC       byte address of ID_INSTR
//   PERF_FETCH  (macro only) count of IREQ=1 cycles
//   PERF_KILL   (macro only) count of responses/held entries discarded by REDIR

module risc_toy_fetch
    import risc_toy_pkg::*;
#(
    parameter logic [IAW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            IREQ,
    output logic [IAW-1:0]  IADDR,
    input  logic [XLEN-1:0] INSTR,
    input  logic            STALL,
    input  logic            REDIR,
    input  logic [IAW-1:0]  REDIR_ADDR,
    output logic            ID_VALID,
    output logic [XLEN-1:0] ID_INSTR,
    output logic [XLEN-1:0] ID_PC
`ifdef RISC_TOY_FETCH_PERF_EN
    ,
    output logic [31:0]     PERF_FETCH,
    output logic [31:0]     PERF_KILL
`endif
);

    fetch_state_e    state_q, state_d;
    logic [IAW-1:0]  pc_q, pc_d;
    logic            req_v_q, req_v_d;
    logic [IAW-1:0]  req_pc_q, req_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;

    logic            ireq;
    logic            hold_load, hold_clear;
    logic            hold_v;
    logic [XLEN-1:0] hold_instr;
    logic [IAW-1:0]  hold_pc;

    risc_toy_fetch_skid u_skid (
        .clk     (CLK),
        .rst     (RST),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .instr_i (INSTR),
        .pc_i    (req_pc_q),
        .valid_o (hold_v),
        .instr_o (hold_instr),
        .pc_o    (hold_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_v_d    = 1'b0;
        req_pc_d   = req_pc_q;
        ireq       = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!STALL) begin
                    ireq     = 1'b1;
                    pc_d     = pc_q + 30'd1;
                    req_v_d  = 1'b1;
                    req_pc_d = pc_q;
                end else if (req_v_q) begin
                    // The response arriving now has nowhere to go; park it.
                    hold_load = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!STALL) begin
                    ireq       = 1'b1;
                    pc_d       = pc_q + 30'd1;
                    req_v_d    = 1'b1;
                    req_pc_d   = pc_q;
                    hold_clear = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Redirect overrides everything: the outstanding response and any
        // held entry belong to the wrong path.
        if (REDIR) begin
            ireq       = 1'b1;
            pc_d       = REDIR_ADDR + 30'd1;
            req_v_d    = 1'b1;
            req_pc_d   = REDIR_ADDR;
            hold_load  = 1'b0;
            hold_clear = 1'b1;
            state_d    = RUN;
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (REDIR) begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
        end else if (!STALL) begin
            if (hold_v) begin
                id_valid_d = 1'b1;
                id_instr_d = hold_instr;
                id_pc_d    = word_to_byte(hold_pc);
            end else begin
                id_valid_d = req_v_q;
                id_instr_d = INSTR;
                id_pc_d    = word_to_byte(req_pc_q);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_v_q    <= 1'b0;
            req_pc_q   <= RESET_PC;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_v_q    <= req_v_d;
            req_pc_q   <= req_pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // Request outputs are combinational from REDIR, so reset gates them
    // directly to keep them quiet while RST is high.
    assign IREQ     = ireq & ~RST;
    assign IADDR    = (REDIR && !RST) ? REDIR_ADDR : pc_q;
    assign ID_VALID = id_valid_q;
    assign ID_INSTR = id_instr_q;
    assign ID_PC    = id_pc_q;

`ifdef RISC_TOY_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_kill_q, perf_kill_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_kill_d  = perf_kill_q;
        if (ireq) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        // At most one of these is set: HOLD never has a request in flight.
        if (REDIR && (req_v_q || hold_v)) begin
            perf_kill_d = perf_kill_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_fetch_q <= '0;
            perf_kill_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_kill_q  <= perf_kill_d;
        end
    end

    assign PERF_FETCH = perf_fetch_q;
    assign PERF_KILL  = perf_kill_q;
`endif

endmodule

// File: tb/tb_risc_toy_fetch.sv
// tb/tb_risc_toy_fetch.sv - self-checking bench for risc_toy_fetch (vector table, corner sequences, random vs model)

module tb_risc_toy_fetch;

    localparam logic [29:0] RST_PC = 30'h10;

    logic        CLK;
    logic        RST;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        STALL;
    logic        REDIR;
    logic [29:0] REDIR_ADDR;
    logic        ID_VALID;
    logic [31:0] ID_INSTR;
    logic [31:0] ID_PC;
`ifdef RISC_TOY_FETCH_PERF_EN
    logic [31:0] PERF_FETCH;
    logic [31:0] PERF_KILL;
`endif

    risc_toy_fetch #(.RESET_PC(RST_PC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IREQ       (IREQ),
        .IADDR      (IADDR),
        .INSTR      (INSTR),
        .STALL      (STALL),
        .REDIR      (REDIR),
        .REDIR_ADDR (REDIR_ADDR),
        .ID_VALID   (ID_VALID),
        .ID_INSTR   (ID_INSTR),
        .ID_PC      (ID_PC)
`ifdef RISC_TOY_FETCH_PERF_EN
        ,
        .PERF_FETCH (PERF_FETCH),
        .PERF_KILL  (PERF_KILL)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_f(input logic [29:0] a);
        return {2'b00, a};
    endfunction

    // Synchronous memory: request seen mid-cycle, data presented just after the next edge.
    logic        mem_req;
    logic [29:0] mem_addr;
    initial begin
        mem_req  = 1'b0;
        mem_addr = '0;
        INSTR    = '0;
    end
    always @(negedge CLK) begin
        mem_req  = IREQ;
        mem_addr = IADDR;
    end
    always @(posedge CLK) begin
        #1;
        INSTR = mem_req ? mem_f(mem_addr) : $urandom;
    end

    int n_checks;
    int n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a queue of fetched-but-undelivered addresses plus the
    // visible ID contents.
    logic [29:0] pipe[$];
    logic [29:0] m_next;
    logic        m_boot;
    logic        m_valid;
    logic        m_zero;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_kill;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [29:0] raddr;
        logic        e_ireq;
        logic [29:0] e_iaddr;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tv[$];
    vec_t nov;

    task automatic model_reset();
        pipe.delete();
        m_next  = RST_PC;
        m_boot  = 1'b1;
        m_valid = 1'b0;
        m_zero  = 1'b1;
        m_instr = '0;
        m_pc    = '0;
        m_fetch = '0;
        m_kill  = '0;
    endtask

    // Called at posedge+1; applies inputs for one cycle, checks at negedge.
    task automatic step(input logic st, input logic rd, input logic [29:0] ra,
                        input vec_t v, input bit use_v);
        logic        e_ireq;
        logic [29:0] a;
        STALL      = st;
        REDIR      = rd;
        REDIR_ADDR = ra;
        @(negedge CLK);
        e_ireq = rd ? 1'b1 : (m_boot ? 1'b0 : !st);
        chk("ireq", {31'b0, IREQ}, {31'b0, e_ireq});
        if (e_ireq) chk("iaddr", {2'b0, IADDR}, {2'b0, (rd ? ra : m_next)});
        chk("id_valid", {31'b0, ID_VALID}, {31'b0, m_valid});
        if (m_valid) begin
            chk("id_instr", ID_INSTR, m_instr);
            chk("id_pc", ID_PC, m_pc);
        end else if (m_zero) begin
            chk("id_instr_zero", ID_INSTR, 32'h0);
        end
`ifdef RISC_TOY_FETCH_PERF_EN
        chk("perf_fetch", PERF_FETCH, m_fetch);
        chk("perf_kill", PERF_KILL, m_kill);
`endif
        if (use_v) begin
            chk("vec_ireq", {31'b0, IREQ}, {31'b0, v.e_ireq});
            if (v.e_ireq) chk("vec_iaddr", {2'b0, IADDR}, {2'b0, v.e_iaddr});
            chk("vec_valid", {31'b0, ID_VALID}, {31'b0, v.e_valid});
            if (v.e_valid) chk("vec_instr", ID_INSTR, v.e_instr);
        end
        // Advance the model across the coming edge.
        if (e_ireq) m_fetch++;
        if (rd) begin
            if (pipe.size() > 0) m_kill++;
            pipe.delete();
            pipe.push_back(ra);
            m_next  = ra + 30'd1;
            m_valid = 1'b0;
            m_zero  = 1'b1;
        end else if (!st) begin
            if (pipe.size() > 0) begin
                a       = pipe.pop_front();
                m_valid = 1'b1;
                m_instr = mem_f(a);
                m_pc    = {a, 2'b00};
            end else begin
                m_valid = 1'b0;
                m_zero  = 1'b0;
            end
            if (!m_boot) begin
                pipe.push_back(m_next);
                m_next = m_next + 30'd1;
            end
        end
        m_boot = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        STALL = 1'b0;
        REDIR = 1'b0;
        REDIR_ADDR = '0;
        @(negedge CLK);
        chk("rst_ireq", {31'b0, IREQ}, 32'h0);
        chk("rst_iaddr", {2'b0, IADDR}, {2'b0, RST_PC});
        chk("rst_valid", {31'b0, ID_VALID}, 32'h0);
        chk("rst_instr", ID_INSTR, 32'h0);
        chk("rst_pc", ID_PC, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic addv(input logic s, input logic r, input logic [29:0] ra, input logic ei,
                        input logic [29:0] ea, input logic ev, input logic [31:0] einst);
        vec_t v;
        v.stall = s; v.redir = r; v.raddr = ra;
        v.e_ireq = ei; v.e_iaddr = ea; v.e_valid = ev; v.e_instr = einst;
        tv.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RST      = 1'b1;
        STALL    = 1'b0;
        REDIR    = 1'b0;
        REDIR_ADDR = '0;
        nov = '{1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 32'h0};
        model_reset();

        //     stall redir raddr          ireq iaddr          valid instr
        addv(0, 0, 30'h0,          0, 30'h0,          0, 32'h0);        // BOOT
        addv(0, 0, 30'h0,          1, 30'h10,         0, 32'h0);
        addv(0, 0, 30'h0,          1, 30'h11,         0, 32'h0);
        addv(0, 0, 30'h0,          1, 30'h12,         1, 32'h10);
        addv(0, 0, 30'h0,          1, 30'h13,         1, 32'h11);
        addv(1, 0, 30'h0,          0, 30'h0,          1, 32'h12);       // stall x3
        addv(1, 0, 30'h0,          0, 30'h0,          1, 32'h12);
        addv(1, 0, 30'h0,          0, 30'h0,          1, 32'h12);
        addv(0, 0, 30'h0,          1, 30'h14,         1, 32'h12);
        addv(0, 0, 30'h0,          1, 30'h15,         1, 32'h13);
        addv(0, 1, 30'h200,        1, 30'h200,        1, 32'h14);       // redirect
        addv(0, 0, 30'h0,          1, 30'h201,        0, 32'h0);
        addv(0, 0, 30'h0,          1, 30'h202,        1, 32'h200);
        addv(1, 0, 30'h0,          0, 30'h0,          1, 32'h201);      // into HOLD
        addv(1, 1, 30'h300,        1, 30'h300,        1, 32'h201);      // redirect + stall
        addv(0, 0, 30'h0,          1, 30'h301,        0, 32'h0);
        addv(0, 0, 30'h0,          1, 30'h302,        1, 32'h300);
        addv(0, 1, 30'h3FFFFFFE,   1, 30'h3FFFFFFE,   1, 32'h301);      // toward wrap
        addv(0, 0, 30'h0,          1, 30'h3FFFFFFF,   0, 32'h0);
        addv(0, 0, 30'h0,          1, 30'h0,          1, 32'h3FFFFFFE);
        addv(0, 0, 30'h0,          1, 30'h1,          1, 32'h3FFFFFFF);
        addv(0, 0, 30'h0,          1, 30'h2,          1, 32'h0);

        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].stall, tv[i].redir, tv[i].raddr, tv[i], 1'b1);
        end

        // Asynchronous reset mid-stream: outputs drop without a clock edge.
        RST = 1'b1;
        #1;
        chk("async_ireq", {31'b0, IREQ}, 32'h0);
        chk("async_valid", {31'b0, ID_VALID}, 32'h0);
        chk("async_iaddr", {2'b0, IADDR}, {2'b0, RST_PC});
        chk("async_instr", ID_INSTR, 32'h0);
        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 30'h0, nov, 1'b0);

`ifdef RISC_TOY_FETCH_PERF_EN
        // Ten fetches then a redirect killing one in-flight response.
        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 30'h0, nov, 1'b0);
        step(1'b0, 1'b1, 30'h80, nov, 1'b0);
        chk("perf_fetch_11", PERF_FETCH, 32'd11);
        chk("perf_kill_1", PERF_KILL, 32'd1);
`endif

        // Randomized traffic against the model.
        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        st;
            logic        rd;
            logic [29:0] ra;
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 19) == 0);
            ra = 30'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 30'h3FFFFFFC + 30'($urandom_range(0, 3));
            step(st, rd, ra, nov, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
